controller_v2: RTL

Multi-cycle sequencer for the 8-bit accumulator datapath (IR, program_counter, reg_file, alu, accum). It drives the same control bundle as the existing controller, with explicit FETCH/DECODE/EXEC phases and latched ALU flags. It adds run control (stall, halt, resume, optional single-step) and a retired-instruction counter. It is a drop-in replacement at the core's CONTROL instance, with extra debug ports.

---
 rtl/controller_v2.sv | 137 +++++++++++++
 1 files changed

// File: rtl/controller_v2.sv
// rtl/controller_v2.sv - FETCH/DECODE/EXEC/HALT sequencer for the 8-bit accumulator core with run control and retire counter
// Optional single-step support is compiled in with `define CTRL_STEP_EN.
module controller_v2 #(
  parameter int RETIRE_W     = 16,
  parameter bit HALT_ON_RSVD = 1'b1
) (
  input  logic                clk,
  input  logic                CLB,
  input  logic [3:0]          op,
  input  logic                z,
  input  logic                c,
  input  logic                run_en,
  input  logic                resume,
  input  logic                step,
  output logic                LoadIR,
  output logic                IncPC,
  output logic                SelPC,
  output logic                LoadPC,
  output logic                LoadReg,
  output logic                LoadAcc,
  output logic [1:0]          SelAcc,
  output logic [3:0]          SelALU,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                zf_q, zf_d;
  logic                cf_q, cf_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                go;

  // A fetch may start from normal running or from a single-step request while stalled.
`ifdef CTRL_STEP_EN
  assign go = run_en | step;
`else
  assign go = run_en | (step & 1'b0);
`endif

  always_ff @(posedge clk) begin
    if (!CLB) begin
      state_q   <= S_RST;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      zf_q      <= zf_d;
      cf_q      <= cf_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    zf_d      = zf_q;
    cf_d      = cf_q;
    retired_d = retired_q;
    LoadIR    = 1'b0;
    IncPC     = 1'b0;
    SelPC     = 1'b0;
    LoadPC    = 1'b0;
    LoadReg   = 1'b0;
    LoadAcc   = 1'b0;
    SelAcc    = 2'd0;
    SelALU    = 4'd0;
    halted    = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        if (go) begin
          LoadIR  = 1'b1;
          IncPC   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        state_d   = S_FETCH;
        retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
        case (op)
          4'h1: begin
            LoadAcc = 1'b1;
            SelAcc  = 2'd0;
          end
          4'h2: begin
            LoadAcc = 1'b1;
            SelAcc  = 2'd1;
          end
          4'h3: LoadReg = 1'b1;
          4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            LoadAcc = 1'b1;
            SelAcc  = 2'd2;
            SelALU  = op - 4'd4;
            zf_d    = z;
            cf_d    = c;
          end
          4'hA: LoadPC = 1'b1;
          4'hB: begin
            LoadPC = 1'b1;
            SelPC  = 1'b1;
          end
          4'hC: LoadPC = zf_q;
          4'hD: LoadPC = cf_q;
          4'hE: begin
            if (HALT_ON_RSVD) state_d = S_HALT;
          end
          4'hF: state_d = S_HALT;
          default: ;
        endcase
      end

      // PC already points past the halting instruction, so resume simply refetches.
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_d = S_FETCH;
      end

      default: state_d = S_RST;
    endcase
  end

  assign retired = retired_q;

endmodule
